tt_sweep_ctrl: RTL and testbench
================================

TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning cycles each input vector is held before the DUT output is sampled; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1, begins a 16-vector sweep when sampled high in IDLE.
REQ-005 SHALL have port abort, input, 1, cancels a running sweep.
REQ-006 SHALL have port expected_tt, input, 16, the target truth table; bit i is the expected output for vector index i.
REQ-007 SHALL have port dut_out, input, 1, the output of the combinational 4-input gate under test.
REQ-008 SHALL have port dut_in, output, 4, the vector driving the gate: dut_in[3] to input _0, dut_in[2] to _1, dut_in[1] to _2, dut_in[0] to _3.
REQ-009 SHALL have port busy, output, 1, high in SETTLE and SAMPLE.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse at sweep completion.
REQ-011 SHALL have port pass, output, 1, high when the last completed sweep had zero mismatches.
REQ-012 SHALL have port captured_tt, output, 16, the sampled DUT outputs; bit i is the result for index i.
REQ-013 SHALL have port mismatch_cnt, output, 5, the number of mismatching indices, 0..16.
REQ-014 SHALL have port first_fail_idx, output, 4, the lowest mismatching index; valid only when mismatch_cnt != 0.

Function
REQ-015 SHALL implement the FSM states IDLE, SETTLE, SAMPLE and DONE.
REQ-016 SHALL, in IDLE with start=1, latch expected_tt and clear captured_tt, mismatch_cnt, first_fail_idx and pass, then set idx=0, settle count=0 and go to SETTLE.
REQ-017 SHALL drive dut_in=idx in SETTLE and SAMPLE, and dut_in=0 in IDLE and DONE.
REQ-018 SHALL remain in SETTLE for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-019 SHALL, in SAMPLE (one cycle): set captured_tt[idx]=dut_out; on mismatch with latched expected bit, increment mismatch_cnt; on the first mismatch of the sweep, set first_fail_idx=idx.
REQ-020 SHALL, at the end of SAMPLE, go to DONE if idx=15, otherwise increment idx and return to SETTLE.
REQ-021 SHALL make DONE last one cycle with done=1, set pass=1 if the final mismatch_cnt is 0, and then return to IDLE.
REQ-022 SHALL, with start sampled in cycle 0, assert done in cycle 16*(SETTLE_CYCLES+1)+1 (cycle 49 at the default).
REQ-023 SHALL ignore start while busy or in DONE; start held high in IDLE SHALL begin a new sweep each time IDLE is reached.
REQ-024 SHALL ignore changes to expected_tt after the start-cycle latch until the next start.
REQ-025 SHALL, on abort=1 in SETTLE or SAMPLE, go to IDLE next cycle, with no done pulse, no capture that cycle, pass=0, and the partial captured_tt and mismatch_cnt held.
REQ-026 SHALL give abort priority over SAMPLE completion when both occur in the same cycle.
REQ-027 SHALL hold mismatch_cnt at 16 or less; the 5-bit width never wraps.
REQ-028 SHALL hold all results stable from DONE until the next accepted start.

Reset
REQ-029 SHALL, on a clock edge with rst_n=0, set: state=IDLE, idx=0, dut_in=0, busy=0, done=0, pass=0, captured_tt=0, mismatch_cnt=0, first_fail_idx=0.
REQ-030 SHALL let reset asserted mid-sweep override start and abort, discard the sweep, and produce no done pulse.

Verification
REQ-031 SHALL cover: behavioural DUT as a 0xCBD6 lookup, expected_tt=0xCBD6, start pulse -> done in cycle 49, captured_tt=0xCBD6, mismatch_cnt=0, pass=1.
REQ-032 SHALL cover: DUT 0xCBD6, expected_tt=0xCBD7 -> captured_tt=0xCBD6, mismatch_cnt=1, first_fail_idx=0, pass=0.
REQ-033 SHALL cover: DUT constant 0, expected_tt=0xFFFF -> mismatch_cnt=16, first_fail_idx=0, pass=0, with no counter wrap.
REQ-034 SHALL cover: SETTLE_CYCLES=1 and a DUT model with one cycle of latency -> correct capture, done in cycle 33; the dut_in sequence observed is 0..15, each held 2 cycles.
REQ-035 SHALL cover: abort at cycle 10, then start again -> no done for the first sweep; the second sweep completes normally with results cleared at its start.
REQ-036 SHALL cover: rst_n=0 at cycle 20 of a sweep, and start pulses while busy -> all outputs take reset values; the busy-time starts are ignored.

Source files
------------

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller: walks a 4-input combinational gate through all
// 16 input vectors, samples its output after a settle time and scores it against a target table.
module tt_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] expected_tt,
    input  logic        dut_out,
    output logic [3:0]  dut_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] captured_tt,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_fail_idx,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  settle_q, settle_d;
    logic [15:0] exp_q, exp_d;
    logic [15:0] cap_q, cap_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  ffi_q, ffi_d;
    logic        pass_q, pass_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= 4'd0;
            settle_q <= 4'd0;
            exp_q    <= 16'd0;
            cap_q    <= 16'd0;
            cnt_q    <= 5'd0;
            ffi_q    <= 4'd0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            exp_q    <= exp_d;
            cap_q    <= cap_d;
            cnt_q    <= cnt_d;
            ffi_q    <= ffi_d;
            pass_q   <= pass_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        exp_d    = exp_q;
        cap_d    = cap_q;
        cnt_d    = cnt_q;
        ffi_d    = ffi_q;
        pass_d   = pass_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_d    = expected_tt;
                    cap_d    = 16'd0;
                    cnt_d    = 5'd0;
                    ffi_d    = 4'd0;
                    pass_d   = 1'b0;
                    idx_d    = 4'd0;
                    settle_d = 4'd0;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    pass_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            ST_SAMPLE: begin
                // Abort wins over the sample, so an aborted index is never captured.
                if (abort) begin
                    pass_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cap_d[idx_q] = dut_out;
                    if (dut_out != exp_q[idx_q]) begin
                        if (cnt_q == 5'd0) begin
                            ffi_d = idx_q;
                        end
                        if (cnt_q != 5'd16) begin
                            cnt_d = cnt_q + 5'd1;
                        end
                    end
                    if (idx_q == 4'd15) begin
                        pass_d  = (cnt_d == 5'd0);
                        state_d = ST_DONE;
                    end else begin
                        idx_d    = idx_q + 4'd1;
                        settle_d = 4'd0;
                        state_d  = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy           = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done           = (state_q == ST_DONE);
    assign dut_in         = busy ? idx_q : 4'd0;
    assign pass           = pass_q;
    assign captured_tt    = cap_q;
    assign mismatch_cnt   = cnt_q;
    assign first_fail_idx = ffi_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Randomised bench for tt_sweep_ctrl: a lookup-table gate model, a scoreboard of
// expected sweep results popped on every done pulse, plus directed abort/reset/latency cases.
module tb_tt_sweep_ctrl;

    localparam int S = 2;
    localparam int SWEEP = 16 * (S + 1) + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] expected_tt = 16'd0;
    logic        dut_out;
    logic [3:0]  dut_in;
    logic        busy, done, pass;
    logic [15:0] captured_tt;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail_idx;
    logic [1:0]  dbg_state;
    logic [15:0] dut_tt = 16'hCBD6;

    // second instance: one-cycle settle, gate model with one cycle of latency
    logic        b_start = 1'b0;
    logic        b_abort = 1'b0;
    logic [15:0] b_expected_tt = 16'd0;
    logic        b_dut_q = 1'b0;
    logic [3:0]  b_dut_in;
    logic        b_busy, b_done, b_pass;
    logic [15:0] b_captured_tt;
    logic [4:0]  b_mismatch_cnt;
    logic [3:0]  b_first_fail_idx;
    logic [1:0]  b_dbg_state;
    logic [15:0] b_tt = 16'd0;

    typedef struct {
        logic [15:0] cap;
        logic [4:0]  cnt;
        logic [3:0]  ffi;
        logic        pass;
        int          done_at;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   edge_cnt = 0;

    tt_sweep_ctrl #(.SETTLE_CYCLES(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .expected_tt(expected_tt), .dut_out(dut_out), .dut_in(dut_in),
        .busy(busy), .done(done), .pass(pass), .captured_tt(captured_tt),
        .mismatch_cnt(mismatch_cnt), .first_fail_idx(first_fail_idx),
        .dbg_state(dbg_state)
    );

    tt_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
        .expected_tt(b_expected_tt), .dut_out(b_dut_q), .dut_in(b_dut_in),
        .busy(b_busy), .done(b_done), .pass(b_pass), .captured_tt(b_captured_tt),
        .mismatch_cnt(b_mismatch_cnt), .first_fail_idx(b_first_fail_idx),
        .dbg_state(b_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    assign dut_out = dut_tt[dut_in];
    always @(posedge clk) b_dut_q <= b_tt[b_dut_in];

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result of sweeping the first n indices of gate table tt against target et.
    function automatic exp_t model(input logic [15:0] tt, input logic [15:0] et,
                                   input int n, input int done_at);
        exp_t        e;
        logic [15:0] mask;
        logic [15:0] diff;
        mask = (n >= 16) ? 16'hFFFF : 16'((32'd1 << n) - 1);
        e.cap = tt & mask;
        diff = (e.cap ^ et) & mask;
        e.cnt = 5'($countones(diff));
        e.ffi = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (diff[i]) e.ffi = 4'(i);
        end
        e.pass = (n == 16) && (diff == 16'd0);
        e.done_at = done_at;
        return e;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(edge_cnt), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_cycle", 32'(edge_cnt), 32'(e.done_at));
                check("captured_tt", 32'(captured_tt), 32'(e.cap));
                check("mismatch_cnt", 32'(mismatch_cnt), 32'(e.cnt));
                check("pass", 32'(pass), 32'(e.pass));
                if (e.cnt != 5'd0) check("first_fail_idx", 32'(first_fail_idx), 32'(e.ffi));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
        check({tag, "_dut_in"}, 32'(dut_in), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_captured"}, 32'(captured_tt), 32'd0);
        check({tag, "_cnt"}, 32'(mismatch_cnt), 32'd0);
        check({tag, "_ffi"}, 32'(first_fail_idx), 32'd0);
    endtask

    // Full sweep; noisy adds busy-time start pulses and target changes after the latch.
    task automatic run_sweep(input logic [15:0] tt, input logic [15:0] et, input bit noisy);
        exp_t e;
        @(negedge clk);
        dut_tt = tt;
        expected_tt = et;
        start = 1'b1;
        e = model(tt, et, 16, edge_cnt + SWEEP);
        exp_q.push_back(e);
        for (int k = 1; k <= SWEEP; k++) begin
            @(negedge clk);
            start = (k == SWEEP) ? 1'b1 : (noisy && ($urandom_range(0, 3) == 0));
            if (noisy) expected_tt = 16'($urandom);
            if (k == 1) begin
                check("cleared_captured", 32'(captured_tt), 32'd0);
                check("cleared_cnt", 32'(mismatch_cnt), 32'd0);
                check("cleared_pass", 32'(pass), 32'd0);
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("idle_after_done", 32'(busy), 32'd0);
        check("sweep_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        check("held_captured", 32'(captured_tt), 32'(e.cap));
        check("held_pass", 32'(pass), 32'(e.pass));
    endtask

    // start held high across DONE: a second sweep must begin as soon as IDLE is reached.
    task automatic run_held(input logic [15:0] tt, input logic [15:0] et);
        @(negedge clk);
        dut_tt = tt;
        expected_tt = et;
        start = 1'b1;
        exp_q.push_back(model(tt, et, 16, edge_cnt + SWEEP));
        exp_q.push_back(model(tt, et, 16, edge_cnt + 2 * SWEEP + 1));
        repeat (SWEEP + 2) @(negedge clk);
        start = 1'b0;
        repeat (SWEEP) @(negedge clk);
        check("held_start_drained", 32'(exp_q.size()), 32'd0);
        check("held_start_idle", 32'(busy), 32'd0);
    endtask

    task automatic run_abort(input int a, input logic [15:0] tt, input logic [15:0] et);
        exp_t e;
        @(negedge clk);
        dut_tt = tt;
        expected_tt = et;
        start = 1'b1;
        e = model(tt, et, (a - 1) / (S + 1), 0);
        for (int k = 1; k <= a; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == a) abort = 1'b1;
        end
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_dut_in", 32'(dut_in), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
        check("abort_captured", 32'(captured_tt), 32'(e.cap));
        check("abort_cnt", 32'(mismatch_cnt), 32'(e.cnt));
        if (e.cnt != 5'd0) check("abort_ffi", 32'(first_fail_idx), 32'(e.ffi));
        repeat (4) @(negedge clk);
        check("abort_held_captured", 32'(captured_tt), 32'(e.cap));
    endtask

    task automatic run_reset_mid_sweep();
        @(negedge clk);
        dut_tt = 16'($urandom);
        expected_tt = 16'($urandom);
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = (k == 5 || k == 12 || k == 20);
            abort = (k == 20);
            if (k == 20) rst_n = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check_reset_values("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (SWEEP + 2) @(negedge clk);
        check("midreset_no_restart", 32'(busy), 32'd0);
        check("midreset_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Latency-1 gate with one settle cycle: each vector held 2 cycles, done at cycle 33.
    task automatic run_latency_case();
        exp_t e;
        int   done_k;
        int   trace_err;
        done_k = -1;
        trace_err = 0;
        @(negedge clk);
        b_tt = 16'($urandom);
        b_expected_tt = 16'($urandom);
        b_start = 1'b1;
        e = model(b_tt, b_expected_tt, 16, 0);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            b_start = 1'b0;
            if (b_dut_in !== ((k <= 32) ? 4'((k - 1) / 2) : 4'd0)) trace_err++;
            if (b_done === 1'b1 && done_k < 0) done_k = k;
        end
        check("lat_dut_in_trace_errors", 32'(trace_err), 32'd0);
        check("lat_done_cycle", 32'(done_k), 32'd33);
        check("lat_captured", 32'(b_captured_tt), 32'(e.cap));
        check("lat_cnt", 32'(b_mismatch_cnt), 32'(e.cnt));
        check("lat_pass", 32'(b_pass), 32'(e.pass));
        if (e.cnt != 5'd0) check("lat_ffi", 32'(b_first_fail_idx), 32'(e.ffi));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        run_sweep(16'hCBD6, 16'hCBD6, 1'b0);
        run_sweep(16'hCBD6, 16'hCBD7, 1'b0);
        run_sweep(16'h0000, 16'hFFFF, 1'b0);
        run_sweep(16'hCBD6, 16'hCBD6, 1'b1);
        run_held(16'($urandom), 16'($urandom));

        run_abort(10, 16'($urandom), 16'($urandom));
        run_sweep(16'($urandom), 16'($urandom), 1'b1);
        run_abort(9, 16'hCBD6, 16'h0000);
        run_abort($urandom_range(1, SWEEP - 2), 16'($urandom), 16'($urandom));

        run_reset_mid_sweep();

        for (int i = 0; i < 6; i++) begin
            logic [15:0] tt;
            logic [15:0] et;
            tt = 16'($urandom);
            et = ($urandom_range(0, 2) == 0) ? tt : (tt ^ 16'($urandom_range(1, 16'hFFFF)));
            run_sweep(tt, et, 1'b1);
        end

        run_latency_case();

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
